// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter in front of one picorv32-style memory port.
// One transaction at a time; a watchdog aborts requests the memory never answers.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  output logic        m0_error,
  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        m1_error,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {StIdle, StBusy, StAbort} state_t;

  localparam logic [15:0] TimerLast = 16'(TIMEOUT - 1);

  state_t      state;
  logic        grant;
  logic        last_grant;
  logic [15:0] timer;

  logic req_any;
  logic pick;
  logic expire;
  logic done_ok;
  logic abort;

  always_comb begin
    req_any = m0_valid | m1_valid;
    // On a tie the master that did not win last time goes next.
    pick    = (m0_valid && m1_valid) ? ~last_grant : m1_valid;
    expire  = (TIMEOUT != 0) && (timer == TimerLast);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= StIdle;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      timer      <= 16'd0;
      mem_valid  <= 1'b0;
      mem_instr  <= 1'b0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
      mem_wstrb  <= 4'd0;
    end else begin
      unique case (state)
        StIdle: begin
          if (req_any) begin
            grant      <= pick;
            last_grant <= pick;
            timer      <= 16'd0;
            mem_valid  <= 1'b1;
            mem_instr  <= pick ? m1_instr : m0_instr;
            mem_addr   <= pick ? m1_addr  : m0_addr;
            mem_wdata  <= pick ? m1_wdata : m0_wdata;
            mem_wstrb  <= pick ? m1_wstrb : m0_wstrb;
            state      <= StBusy;
          end
        end
        StBusy: begin
          // Completion takes priority over a watchdog expiry in the same cycle.
          if (mem_ready) begin
            mem_valid <= 1'b0;
            state     <= StIdle;
          end else if (expire) begin
            mem_valid <= 1'b0;
            state     <= StAbort;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        StAbort: state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

  always_comb begin
    done_ok  = (state == StBusy) && mem_ready;
    abort    = (state == StAbort);
    m0_ready = (done_ok || abort) && !grant;
    m1_ready = (done_ok || abort) && grant;
    m0_error = abort && !grant;
    m1_error = abort && grant;
    m0_rdata = (done_ok && !grant) ? mem_rdata : 32'd0;
    m1_rdata = (done_ok && grant)  ? mem_rdata : 32'd0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: cycle-by-cycle vector table plus
// hand-written sequences for saturation, write forwarding and async reset.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_valid, m0_instr, m0_ready, m0_error;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [3:0]  m0_wstrb;
  logic        m1_valid, m1_instr, m1_ready, m1_error;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m1_wstrb;
  logic        mem_valid, mem_instr, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .m0_valid  (m0_valid),
    .m0_instr  (m0_instr),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_wstrb  (m0_wstrb),
    .m0_ready  (m0_ready),
    .m0_rdata  (m0_rdata),
    .m0_error  (m0_error),
    .m1_valid  (m1_valid),
    .m1_instr  (m1_instr),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_wstrb  (m1_wstrb),
    .m1_ready  (m1_ready),
    .m1_rdata  (m1_rdata),
    .m1_error  (m1_error),
    .mem_valid (mem_valid),
    .mem_instr (mem_instr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // One row per cycle: inputs driven just after the rising edge, outputs
  // checked at the following falling edge.
  typedef struct {
    logic        rst;
    logic        v0;
    logic        v1;
    logic [31:0] a0;
    logic [31:0] a1;
    logic        rdy;
    logic [31:0] rd;
    logic        e_mv;
    logic [31:0] e_addr;
    logic        e_instr;
    logic        e_r0;
    logic        e_r1;
    logic        e_err;
    logic [31:0] e_rd;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(int rst, int v0, int v1, logic [31:0] a0, logic [31:0] a1,
                              int rdy, logic [31:0] rd, int e_mv, logic [31:0] e_addr,
                              int e_instr, int e_r0, int e_r1, int e_err,
                              logic [31:0] e_rd);
    vec_t v;
    v.rst = (rst != 0);
    v.v0 = (v0 != 0);
    v.v1 = (v1 != 0);
    v.a0 = a0;
    v.a1 = a1;
    v.rdy = (rdy != 0);
    v.rd = rd;
    v.e_mv = (e_mv != 0);
    v.e_addr = e_addr;
    v.e_instr = (e_instr != 0);
    v.e_r0 = (e_r0 != 0);
    v.e_r1 = (e_r1 != 0);
    v.e_err = (e_err != 0);
    v.e_rd = e_rd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  initial begin
    int seq[$];
    logic drop0, drop1;
    reset = 1'b0;
    m0_valid = 0; m0_instr = 1; m0_addr = 0; m0_wdata = 32'hA5A5A5A5; m0_wstrb = 0;
    m1_valid = 0; m1_instr = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
    mem_ready = 0; mem_rdata = 0;

    // Single read with two wait cycles.
    vq.push_back(mk(1, 1, 0, 'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 1, 0, 'h100, 0, 0, 0, 1, 'h100, 1, 0, 0, 0, 0));
    vq.push_back(mk(0, 1, 0, 'h100, 0, 0, 0, 1, 'h100, 1, 0, 0, 0, 0));
    vq.push_back(mk(0, 1, 0, 'h100, 0, 1, 'hDEADBEEF, 1, 'h100, 1, 1, 0, 0, 'hDEADBEEF));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Simultaneous first requests, zero-wait memory; mem_ready in IDLE is ignored.
    vq.push_back(mk(1, 1, 1, 'h200, 'h300, 1, 'h11111111, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 1, 1, 'h200, 'h300, 1, 'h11111111, 1, 'h200, 1, 1, 0, 0, 'h11111111));
    vq.push_back(mk(0, 0, 1, 'h200, 'h300, 1, 'h22222222, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 1, 'h200, 'h300, 1, 'h22222222, 1, 'h300, 0, 0, 1, 0, 'h22222222));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Tie with m1 last: m0 wins; then m1 alone.
    vq.push_back(mk(0, 1, 1, 'h210, 'h310, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 1, 1, 'h210, 'h310, 1, 'h33333333, 1, 'h210, 1, 1, 0, 0, 'h33333333));
    vq.push_back(mk(0, 0, 1, 'h210, 'h310, 1, 'h55555555, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 1, 'h210, 'h310, 1, 'h55555555, 1, 'h310, 0, 0, 1, 0, 'h55555555));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Timeout of 4: four BUSY cycles, ABORT in cycle 5 ignores mem_ready.
    vq.push_back(mk(1, 1, 0, 'h500, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++)
      vq.push_back(mk(0, 1, 0, 'h500, 0, 0, 0, 1, 'h500, 1, 0, 0, 0, 0));
    vq.push_back(mk(0, 1, 0, 'h500, 0, 1, 'hCAFEF00D, 0, 0, 0, 1, 0, 1, 0));
    vq.push_back(mk(0, 0, 0, 'h500, 0, 1, 'hCAFEF00D, 0, 0, 0, 0, 0, 0, 0));
    // Tie with m0 last: m1 wins; ready on the expiry cycle completes cleanly.
    vq.push_back(mk(0, 1, 1, 'h500, 'h600, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      vq.push_back(mk(0, 1, 1, 'h500, 'h600, 0, 0, 1, 'h600, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 1, 1, 'h500, 'h600, 1, 'h0000ABCD, 1, 'h600, 0, 0, 1, 0, 'h0000ABCD));
    vq.push_back(mk(0, 1, 0, 'h500, 'h600, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 1, 0, 'h500, 0, 1, 'h44444444, 1, 'h500, 1, 1, 0, 0, 'h44444444));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Reset values, sampled while reset is held.
    next_cycle();
    next_cycle();
    chk("rst mem_valid", mem_valid, 0);
    chk("rst mem_instr", mem_instr, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_wdata", mem_wdata, 0);
    chk("rst mem_wstrb", mem_wstrb, 0);
    chk("rst readies", {m0_ready, m1_ready, m0_error, m1_error}, 0);
    chk("rst rdata", m0_rdata | m1_rdata, 0);
    #2;
    reset = 1'b1;

    foreach (vq[i]) begin
      next_cycle();
      if (vq[i].rst) pulse_reset();
      m0_valid = vq[i].v0;
      m1_valid = vq[i].v1;
      m0_addr = vq[i].a0;
      m1_addr = vq[i].a1;
      mem_ready = vq[i].rdy;
      mem_rdata = vq[i].rd;
      @(negedge clk);
      chk($sformatf("v%0d mem_valid", i), mem_valid, vq[i].e_mv);
      if (vq[i].e_mv) begin
        chk($sformatf("v%0d mem_addr", i), mem_addr, vq[i].e_addr);
        chk($sformatf("v%0d mem_instr", i), mem_instr, vq[i].e_instr);
      end
      chk($sformatf("v%0d m0_ready", i), m0_ready, vq[i].e_r0);
      chk($sformatf("v%0d m1_ready", i), m1_ready, vq[i].e_r1);
      chk($sformatf("v%0d m0_error", i), m0_error, vq[i].e_r0 & vq[i].e_err);
      chk($sformatf("v%0d m1_error", i), m1_error, vq[i].e_r1 & vq[i].e_err);
      chk($sformatf("v%0d m0_rdata", i), m0_rdata, vq[i].e_r0 ? vq[i].e_rd : 32'd0);
      chk($sformatf("v%0d m1_rdata", i), m1_rdata, vq[i].e_r1 ? vq[i].e_rd : 32'd0);
    end

    // Write forwarding from m1; address changes mid-BUSY must not reach the bus.
    next_cycle();
    pulse_reset();
    m0_valid = 0; m1_valid = 1; mem_ready = 0;
    m1_addr = 32'h400; m1_wdata = 32'h12345678; m1_wstrb = 4'b0011;
    next_cycle();
    m1_addr = 32'h800; m1_wdata = 32'h0; m1_wstrb = 4'b1111;
    @(negedge clk);
    chk("wr mem_valid", mem_valid, 1);
    chk("wr mem_addr", mem_addr, 32'h400);
    chk("wr mem_wdata", mem_wdata, 32'h12345678);
    chk("wr mem_wstrb", mem_wstrb, 4'b0011);
    chk("wr mem_instr", mem_instr, 0);
    next_cycle();
    mem_ready = 1; mem_rdata = 32'h0;
    @(negedge clk);
    chk("wr frozen addr", mem_addr, 32'h400);
    chk("wr frozen wdata", mem_wdata, 32'h12345678);
    chk("wr m1_ready", m1_ready, 1);
    next_cycle();
    m1_valid = 0; mem_ready = 0; m1_wstrb = 0; m1_wdata = 0;

    // Saturation: both masters re-request one cycle after each completion.
    next_cycle();
    pulse_reset();
    drop0 = 0; drop1 = 0;
    mem_ready = 1; mem_rdata = 32'h0;
    for (int c = 0; c < 60 && seq.size() < 8; c++) begin
      if (c != 0) next_cycle();
      m0_valid = !drop0;
      m1_valid = !drop1;
      @(negedge clk);
      drop0 = m0_ready;
      drop1 = m1_ready;
      if (m0_ready) seq.push_back(0);
      if (m1_ready) seq.push_back(1);
    end
    chk("rr count", seq.size(), 8);
    foreach (seq[i]) chk($sformatf("rr grant %0d", i), seq[i], i % 2);
    next_cycle();
    m0_valid = 0; m1_valid = 0; mem_ready = 0;
    next_cycle();
    next_cycle();

    // Asynchronous reset mid-BUSY, after m0 has been granted last.
    pulse_reset();
    m0_valid = 1; m0_addr = 32'h700;
    next_cycle();
    @(negedge clk);
    chk("ar busy mem_valid", mem_valid, 1);
    next_cycle();
    mem_ready = 1; mem_rdata = 32'h99999999;
    reset = 1'b0;
    #1;
    chk("ar mem_valid now", mem_valid, 0);
    chk("ar m0_ready", m0_ready, 0);
    chk("ar m0_rdata", m0_rdata, 0);
    m0_valid = 0;
    #1;
    reset = 1'b1;
    mem_ready = 0;
    next_cycle();
    m0_valid = 1; m1_valid = 1; m1_addr = 32'h710;
    @(negedge clk);
    chk("ar idle mem_valid", mem_valid, 0);
    next_cycle();
    mem_ready = 1; mem_rdata = 32'h77777777;
    @(negedge clk);
    chk("ar tie mem_addr", mem_addr, 32'h700);
    chk("ar tie m0_ready", m0_ready, 1);
    chk("ar tie m1_ready", m1_ready, 0);
    next_cycle();
    m0_valid = 0; m1_valid = 0; mem_ready = 0;
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
